// File: rtl/cmp_flag_unit.sv
// rtl/cmp_flag_unit.sv - comparator E/G/L output register with saturating event counters
// Optional run-length tracking of identical results is enabled by defining CMP_STREAK_EN.
module cmp_flag_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             E,
    input  logic             G,
    input  logic             L,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             E_q,
    output logic             G_q,
    output logic             L_q,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             err,
    output logic [CNT_W-1:0] streak_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic accept;
    logic one_hot;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign one_hot  = (E ^ G ^ L) & ~(E & G & L);

    // Output register: a simultaneous consume and accept reloads without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            E_q       <= 1'b0;
            G_q       <= 1'b0;
            L_q       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            E_q       <= E;
            G_q       <= G;
            L_q       <= L;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            eq_cnt <= '0;
            gt_cnt <= '0;
            lt_cnt <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            if (!one_hot) begin
                err <= 1'b1;
            end else if (E) begin
                if (eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
            end else if (G) begin
                if (gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
            end else begin
                if (lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
            end
        end
    end

`ifdef CMP_STREAK_EN
    // last_res of 3'b000 means nothing remembered; it never matches a one-hot input.
    logic [2:0] last_res;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            streak_cnt <= '0;
            last_res   <= 3'b000;
        end else if (accept) begin
            if (!one_hot) begin
                streak_cnt <= '0;
                last_res   <= 3'b000;
            end else begin
                last_res <= {E, G, L};
                if ({E, G, L} != last_res) begin
                    streak_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (streak_cnt != CNT_MAX) begin
                    streak_cnt <= streak_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign streak_cnt = '0;
`endif

endmodule

// File: tb/tb_cmp_flag_unit.sv
// tb/tb_cmp_flag_unit.sv - scoreboard bench for cmp_flag_unit (CNT_W=4)
module tb_cmp_flag_unit;

    localparam int CNT_W = 4;
`ifdef CMP_STREAK_EN
    localparam bit STREAK = 1'b1;
`else
    localparam bit STREAK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, E, G, L, clr;
    logic             out_valid, out_ready, E_q, G_q, L_q, err;
    logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt, streak_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] exp_q[$];

    cmp_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .E(E), .G(G), .L(L), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .E_q(E_q), .G_q(G_q), .L_q(L_q),
        .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
        .err(err), .streak_cnt(streak_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [7:0] sexp(input int v);
        return STREAK ? 8'(v) : 8'd0;
    endfunction

    // Drive one cycle; returns one time unit after the rising edge.
    task automatic step(input logic v, input logic [2:0] egl, input logic ordy,
                        input logic c, input logic r);
        in_valid = v; {E, G, L} = egl; out_ready = ordy; clr = c; rst = r;
        @(negedge clk);
        if (r) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(egl);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every consumed result must match the oldest accepted one.
    always @(negedge clk) begin
        if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL flags: got %b with no expected entry", {E_q, G_q, L_q});
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if ({E_q, G_q, L_q} === e) n_pass++;
                else $display("FAIL flags: got %b expected %b", {E_q, G_q, L_q}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {E_q, G_q, L_q}, 0);
        chk("rst_cnts", {eq_cnt, gt_cnt} | lt_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_streak", streak_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // single accept of G
        step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_G_q", G_q, 1);
        chk("t1_gt_cnt", gt_cnt, 1);
        chk("t1_err", err, 0);
        chk("t1_streak", streak_cnt, sexp(1));
        drain();
        chk("t1_drained", out_valid, 0);

        // backpressure holds the registered result
        step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; {E, G, L} = 3'b001; out_ready = 1'b0;
            #1 chk("t2_in_ready", in_ready, 0);
            step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
            chk("t2_E_q", {E_q, G_q, L_q}, 3'b100);
        end
        chk("t2_eq_cnt", eq_cnt, 1);
        chk("t2_lt_cnt", lt_cnt, 0);
        step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        chk("t2_L_q", {E_q, G_q, L_q}, 3'b001);
        chk("t2_lt_after", lt_cnt, 1);
        chk("t2_streak", streak_cnt, sexp(1));

        // back-to-back without bubbles
        step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
            chk("t3_no_gap", out_valid, 1);
        end
        chk("t3_lt_cnt", lt_cnt, 4);
        chk("t3_streak", streak_cnt, sexp(4));
        drain();

        // saturation at 2^CNT_W-1
        step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
        chk("t4_eq_sat", eq_cnt, 15);
        chk("t4_gt_cnt", gt_cnt, 0);
        chk("t4_lt_cnt", lt_cnt, 0);
        chk("t4_streak_sat", streak_cnt, sexp(15));
        drain();

        // non-one-hot sets err, then clr wins over a simultaneous accept
        step(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
        chk("t5_err", err, 1);
        chk("t5_eq_hold", eq_cnt, 15);
        chk("t5_gt_hold", gt_cnt, 0);
        chk("t5_out_valid", out_valid, 1);
        chk("t5_streak", streak_cnt, 0);
        step(1'b1, 3'b010, 1'b1, 1'b1, 1'b0);
        chk("t5_err_clr", err, 0);
        chk("t5_gt_clr", gt_cnt, 0);
        chk("t5_eq_clr", eq_cnt, 0);
        chk("t5_G_q", G_q, 1);
        chk("t5_valid_clr", out_valid, 1);
        drain();

        // streak run, then reset mid-sequence
        step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        chk("t6_streak1", streak_cnt, sexp(1));
        step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        chk("t6_streak2", streak_cnt, sexp(2));
        step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        chk("t6_streak3", streak_cnt, sexp(3));
        step(1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
        chk("t6_streak4", streak_cnt, sexp(1));
        chk("t6_gt_cnt", gt_cnt, 3);
        step(1'b1, 3'b010, 1'b1, 1'b0, 1'b1);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_flags", {E_q, G_q, L_q}, 0);
        chk("t6_rst_cnts", {eq_cnt, gt_cnt} | lt_cnt, 0);
        chk("t6_rst_streak", streak_cnt, 0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
